// File: rtl/rotate_arbiter_pkg.sv
// Shared constants, state encoding and arbitration helper for rotate_arbiter.
package rotate_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;
  localparam int REQ_N  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Round-robin pick between two requesters: a tie goes to the pointer,
  // a lone requester wins outright. Result is meaningless with no request.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic ptr);
    logic win;
    if (req0 && req1) begin
      win = ptr;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/rotate_arbiter_circular_left_shift_1.sv
// Combinational one-bit circular left rotation of a data word.
module circular_left_shift_1
  import rotate_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // MSB wraps around into the LSB position.
  always_comb begin
    dout = {din[DATA_W-2:0], din[DATA_W-1]};
  end

endmodule

// File: rtl/rotate_arbiter.sv
// Two-requester round-robin arbiter feeding a serial left-rotate engine.
// The winner's operand is rotated one bit per ROTATE cycle until its
// amount is exhausted, then the result is presented for one DONE cycle.
module rotate_arbiter
  import rotate_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [CNT_W-1:0]  n0,
  input  logic [CNT_W-1:0]  n1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic              owner,
  output logic [DATA_W-1:0] r
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                ptr_q, ptr_d;
  logic [1:0]          gnt_q, gnt_d;

  logic                accept;
  logic                winner;
  logic [DATA_W-1:0]   sel_a;
  logic [CNT_W-1:0]    sel_n;
  logic [DATA_W-1:0]   work_rot;

  circular_left_shift_1 u_rot (
    .din  (work_q),
    .dout (work_rot)
  );

  // Arbitration: only an idle engine accepts; requests while busy are ignored.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    accept = 1'b0;
    winner = 1'b0;
    sel_a  = '0;
    sel_n  = '0;
    if (state_q == ST_IDLE && (req0 || req1)) begin
      accept = 1'b1;
      winner = pick_winner(req0, req1, ptr_q);
    end
    sel_a = winner ? a1 : a0;
    sel_n = winner ? n1 : n0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: zero amount skips ROTATE, last rotation goes to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (sel_n == '0) ? ST_DONE : ST_ROTATE;
        end
      end
      ST_ROTATE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: load on acceptance, rotate and count down in ROTATE.
  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = 2'b00;
    if (accept) begin
      work_d  = sel_a;
      cnt_d   = sel_n;
      owner_d = winner;
      ptr_d   = ~winner;
      gnt_d   = winner ? 2'b10 : 2'b01;
    end else if (state_q == ST_ROTATE) begin
      work_d = work_rot;
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath is reset too, because r and owner have defined reset values.
      work_q  <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      gnt_q   <= 2'b00;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs decoded from the registered state and datapath.
  always_comb begin
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DONE);
    gnt   = gnt_q;
    owner = owner_q;
    r     = work_q;
  end

endmodule

// File: tb/tb_rotate_arbiter.sv
// Self-checking bench for rotate_arbiter: directed table, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_rotate_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, a1;
  logic [2:0] n0, n1;
  logic [1:0] gnt;
  logic       busy, done, owner;
  logic [7:0] r;

  int checks   = 0;
  int failures = 0;

  rotate_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .a0    (a0),
    .a1    (a1),
    .n0    (n0),
    .n1    (n1),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .owner (owner),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req0;
    logic [7:0] a0;
    logic [2:0] n0;
    logic       req1;
    logic [7:0] a1;
    logic [2:0] n1;
    logic [1:0] exp_gnt;
    logic       exp_owner;
    logic [7:0] exp_r;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    logic [15:0] d;
    d = {x, x} << (k % 8);
    return d[15:8];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait until done, counting cycles from the first cycle after acceptance.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (busy) busy_cycles++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout waited=%0d cycles", lat);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int lat, bc;

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; a1 = '0; n0 = '0; n1 = '0;

    // Reset state
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gnt", gnt, 0);
    check("rst_owner", owner, 0);
    check("rst_r", r, 8'h00);
    tick();
    rst = 1'b0;

    // Single-transaction table (lone requesters, so the pointer is irrelevant)
    vecs[0] = '{1'b1, 8'h81, 3'd1, 1'b0, 8'h00, 3'd0, 2'b01, 1'b0, 8'h03, 2};
    vecs[1] = '{1'b0, 8'h00, 3'd0, 1'b1, 8'hA5, 3'd0, 2'b10, 1'b1, 8'hA5, 1};
    vecs[2] = '{1'b1, 8'h01, 3'd7, 1'b0, 8'h00, 3'd0, 2'b01, 1'b0, 8'h80, 8};
    vecs[3] = '{1'b0, 8'h00, 3'd0, 1'b1, 8'h3C, 3'd3, 2'b10, 1'b1, 8'hE1, 4};
    vecs[4] = '{1'b1, 8'hFE, 3'd0, 1'b0, 8'h00, 3'd0, 2'b01, 1'b0, 8'hFE, 1};
    vecs[5] = '{1'b0, 8'h00, 3'd0, 1'b1, 8'h96, 3'd5, 2'b10, 1'b1, 8'hD2, 6};

    for (int i = 0; i < 6; i++) begin
      req0 = vecs[i].req0; a0 = vecs[i].a0; n0 = vecs[i].n0;
      req1 = vecs[i].req1; a1 = vecs[i].a1; n1 = vecs[i].n1;
      tick();
      req0 = 1'b0; req1 = 1'b0;
      a0 = 8'h55; a1 = 8'hAA; n0 = 3'd2; n1 = 3'd6;
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].exp_gnt);
      check($sformatf("vec%0d_owner", i), owner, vecs[i].exp_owner);
      wait_done(lat, bc);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_lat);
      check($sformatf("vec%0d_r", i), r, vecs[i].exp_r);
      check($sformatf("vec%0d_owner_done", i), owner, vecs[i].exp_owner);
      tick();
      check($sformatf("vec%0d_idle_busy", i), busy, 0);
      check($sformatf("vec%0d_idle_done", i), done, 0);
      check($sformatf("vec%0d_r_hold", i), r, vecs[i].exp_r);
    end

    // Tie after reset: requester 0 first, one IDLE cycle, then requester 1
    do_reset();
    req0 = 1'b1; a0 = 8'h0F; n0 = 3'd4;
    req1 = 1'b1; a1 = 8'h11; n1 = 3'd1;
    tick();
    req0 = 1'b0;
    check("tie_gnt0", gnt, 2'b01);
    check("tie_owner0", owner, 0);
    wait_done(lat, bc);
    check("tie_r0", r, 8'hF0);
    check("tie_lat0", lat, 5);
    tick();
    check("tie_idle_busy", busy, 0);
    check("tie_idle_gnt", gnt, 0);
    tick();
    req1 = 1'b0;
    check("tie_gnt1", gnt, 2'b10);
    check("tie_owner1", owner, 1);
    wait_done(lat, bc);
    check("tie_r1", r, 8'h22);
    check("tie_owner1_done", owner, 1);
    tick();

    // Reset mid-ROTATE aborts the transaction and resets the pointer
    req0 = 1'b1; a0 = 8'hC3; n0 = 3'd5;
    tick();
    req0 = 1'b0;
    check("abort_gnt", gnt, 2'b01);
    tick();
    tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_r", r, 8'h00);
    check("abort_gnt_clr", gnt, 0);
    check("abort_owner", owner, 0);
    begin
      int seen_done = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (done || busy) seen_done++;
      end
      check("abort_no_done", seen_done, 0);
    end
    req0 = 1'b1; a0 = 8'h01; n0 = 3'd0;
    req1 = 1'b1; a1 = 8'h02; n1 = 3'd0;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    check("abort_tie_gnt", gnt, 2'b01);
    tick();
    tick();

    // Request raised and withdrawn while busy has no effect
    req0 = 1'b1; a0 = 8'h12; n0 = 3'd6;
    tick();
    req0 = 1'b0;
    check("wd_gnt0", gnt, 2'b01);
    req1 = 1'b1; a1 = 8'hFF; n1 = 3'd2;
    tick();
    tick();
    req1 = 1'b0;
    begin
      int extra = 0;
      wait_done(lat, bc);
      check("wd_r", r, rotl(8'h12, 6));
      check("wd_owner", owner, 0);
      for (int k = 0; k < 6; k++) begin
        tick();
        if (gnt != 2'b00 || busy) extra++;
      end
      check("wd_no_extra", extra, 0);
    end

    // Randomized traffic against a transaction-level model
    do_reset();
    begin
      int         busy_left = 0;
      int         m_n = 0;
      logic [7:0] m_a = 8'h00;
      logic       m_owner = 1'b0;
      logic       m_ptr = 1'b0;
      logic [1:0] m_gnt;
      int         rot_amt;
      for (int c = 0; c < 3000; c++) begin
        logic w;
        req0 = ($urandom_range(0, 2) == 0);
        req1 = ($urandom_range(0, 2) == 0);
        a0 = 8'($urandom); a1 = 8'($urandom);
        n0 = 3'($urandom); n1 = 3'($urandom);
        m_gnt = 2'b00;
        if (busy_left == 0 && (req0 || req1)) begin
          if (req0 && req1) w = m_ptr;
          else w = req1;
          m_owner = w;
          m_ptr = ~w;
          m_a = w ? a1 : a0;
          m_n = w ? int'(n1) : int'(n0);
          busy_left = m_n + 1;
          m_gnt = w ? 2'b10 : 2'b01;
        end else if (busy_left > 0) begin
          busy_left--;
        end
        tick();
        rot_amt = (busy_left > 0) ? (m_n + 1 - busy_left) : m_n;
        check("rnd_gnt", gnt, m_gnt);
        check("rnd_busy", busy, busy_left > 0);
        check("rnd_done", done, busy_left == 1);
        check("rnd_owner", owner, m_owner);
        check("rnd_r", r, rotl(m_a, rot_amt));
        if (failures > 20) break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
